// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one RS-232 byte transmitter among NUM_REQ byte streams.
// Build option UART_ARB_SRC_TAG_EN prefixes every granted packet with a source tag byte (TAG_BASE + index).
module uart_tx_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          GAP_TIMEOUT = 65535,
  parameter logic [7:0]  TAG_BASE    = 8'hA0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   gap_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d, g_q, g_d, pick;
  logic               pick_ok;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               gto_q, gto_d;
  logic               tag_phase;
  logic [7:0]         cur_byte;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // First requesting index at or after rr_q; the lowest offset is assigned last and wins.
  always_comb begin
    logic [IW-1:0] sel;
    sel     = '0;
    pick    = rr_q;
    pick_ok = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[sel]) begin
        pick    = sel;
        pick_ok = 1'b1;
      end
    end
  end

  assign cur_byte = req_data[{g_q, 3'b000} +: 8];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    g_d       = g_q;
    grant_d   = grant_q;
    last_d    = last_q;
    data_d    = data_q;
    gap_d     = gap_q;
    gto_d     = 1'b0;
    tx_start  = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          g_d     = pick;
          grant_d = NUM_REQ'(1) << pick;
          gap_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tag_phase) begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            data_d   = TAG_BASE + 8'(g_q);
            last_d   = 1'b0;
            state_d  = WAIT_HI;
          end
        end else if (!tx_busy && req_valid[g_q]) begin
          tx_start       = 1'b1;
          req_ready[g_q] = 1'b1;
          data_d         = cur_byte;
          last_d         = req_last[g_q];
          gap_d          = '0;
          state_d        = WAIT_HI;
        end else if (GAP_TIMEOUT > 0 && !req_valid[g_q]) begin
          if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
            gto_d   = 1'b1;
            gap_d   = '0;
            grant_d = '0;
            rr_d    = next_idx(g_q);
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      // Busy rises one cycle after a start; waiting for it prevents a second start on stale busy=0.
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = next_idx(g_q);
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UART_ARB_SRC_TAG_EN
  logic tag_q;
  assign tag_phase = tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                         tag_q <= 1'b0;
    else if (state_q == IDLE && pick_ok) tag_q <= 1'b1;
    else if (tag_phase && tx_start)      tag_q <= 1'b0;
  end
`else
  assign tag_phase = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      gap_q   <= '0;
      gto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      gto_q   <= gto_d;
    end
  end

  assign tx_data     = data_d;
  assign grant       = grant_q;
  assign gap_timeout = gto_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, then packet sequences against a transmitter model.
// Honours UART_ARB_SRC_TAG_EN by running the tag sequence in that build.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int GAP   = 10;
  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_start, tx_busy, gap_timeout;
  logic [7:0]  tx_data;

  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(GAP), .TAG_BASE(8'hA0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .gap_timeout(gap_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Input sources: vector table (model_en=0) or requester/transmitter models (model_en=1).
  logic        model_en = 1'b0;
  logic [3:0]  vec_valid = '0, vec_last = '0;
  logic [31:0] vec_data = '0;
  logic        vec_busy = 1'b0;
  logic [3:0]  q_valid = '0, q_last = '0;
  logic [31:0] q_data = '0;
  logic        model_busy = 1'b0, hold_busy = 1'b0;

  assign req_valid = model_en ? q_valid : vec_valid;
  assign req_last  = model_en ? q_last  : vec_last;
  assign req_data  = model_en ? q_data  : vec_data;
  assign tx_busy   = model_en ? (model_busy | hold_busy) : vec_busy;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       start_seen = 1'b0;
  logic [3:0] ready_seen = '0;
  logic [7:0] log_d[$];
  logic [3:0] log_g[$];
  logic [3:0] log_r[$];
  int         log_c[$];
  int         rdy_cnt[N] = '{default: 0};
  int         gto_cnt = 0;
  int         gto_cyc = 0;
  logic [3:0] gto_grant = '0;

  always @(negedge clk) begin
    start_seen = tx_start;
    ready_seen = req_ready;
    if (tx_start) begin
      log_d.push_back(tx_data);
      log_g.push_back(grant);
      log_r.push_back(req_ready);
      log_c.push_back(cyc);
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
    if (gap_timeout) begin
      gto_cnt++;
      gto_cyc   = cyc;
      gto_grant = grant;
    end
    check("inv_grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("inv_start_while_busy", 32'(tx_start & tx_busy), 32'd0);
    if (req_ready != 4'b0000) check("inv_ready_with_start", 32'({tx_start, req_ready}), 32'({1'b1, grant}));
  end

  // Transmitter model: busy for FRAME cycles starting the cycle after a start.
  int busy_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (start_seen) busy_cnt = FRAME;
    else if (busy_cnt > 0) busy_cnt--;
    model_busy = (busy_cnt > 0);
  end

  // Requester model: per-requester byte list {last, data}; a req_ready pulse advances the read pointer.
  logic [8:0] pkt[N][32];
  int         len[N] = '{default: 0};
  int         rd[N]  = '{default: 0};
  always begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ready_seen[i] && rd[i] < len[i]) rd[i] = rd[i] + 1;
      if (rd[i] < len[i]) begin
        q_valid[i]        = 1'b1;
        q_last[i]         = pkt[i][rd[i]][8];
        q_data[8*i +: 8]  = pkt[i][rd[i]][7:0];
      end else begin
        q_valid[i]        = 1'b0;
        q_last[i]         = 1'b0;
        q_data[8*i +: 8]  = 8'h00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic add(input int r, input logic [7:0] d, input logic l);
    pkt[r][len[r]] = {l, d};
    len[r] = len[r] + 1;
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (rd[i] != len[i]) return 1'b0;
    return grant == 4'b0000;
  endfunction

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      ok = all_done();
    end
    check({name, "_completes"}, 32'(ok), 32'd1);
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] d, input logic [3:0] g);
    if (idx < log_d.size()) begin
      check({name, "_data"}, 32'(log_d[idx]), 32'(d));
      check({name, "_grant"}, 32'(log_g[idx]), 32'(g));
    end else begin
      check({name, "_present"}, 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_grant"}, 32'(grant), 32'd0);
    check({name, "_tx_start"}, 32'(tx_start), 32'd0);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
    check({name, "_gap_timeout"}, 32'(gap_timeout), 32'd0);
  endtask

  typedef struct packed {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        busy;
    logic        e_start;
    logic [7:0]  e_data;
    logic [3:0]  e_ready;
    logic [3:0]  e_grant;
  } vec_t;

  vec_t tv[19];

  initial begin
    int base, base2, rbase, g0, rel_cyc;
    bit seen;

    repeat (2) tick();
    @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

`ifndef UART_ARB_SRC_TAG_EN
    // Requester 2 sends 11,22(last) with busy pacing, then 0 is picked from rr_ptr=3, then 3 from rr_ptr=1.
    tv[0]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tv[1]  = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tv[2]  = '{4'b0100, 4'b0000, 32'h0011_0000, 1'b0, 1'b1, 8'h11, 4'b0100, 4'b0100};
    tv[3]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b0, 1'b0, 8'h11, 4'b0000, 4'b0100};
    tv[4]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b1, 1'b0, 8'h11, 4'b0000, 4'b0100};
    tv[5]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b1, 1'b0, 8'h11, 4'b0000, 4'b0100};
    tv[6]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b0, 1'b0, 8'h11, 4'b0000, 4'b0100};
    tv[7]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b1, 1'b0, 8'h11, 4'b0000, 4'b0100};
    tv[8]  = '{4'b0100, 4'b0100, 32'h0022_0000, 1'b0, 1'b1, 8'h22, 4'b0100, 4'b0100};
    tv[9]  = '{4'b0001, 4'b0001, 32'h0000_0033, 1'b0, 1'b0, 8'h22, 4'b0000, 4'b0100};
    tv[10] = '{4'b0001, 4'b0001, 32'h0000_0033, 1'b1, 1'b0, 8'h22, 4'b0000, 4'b0100};
    tv[11] = '{4'b0001, 4'b0001, 32'h0000_0033, 1'b0, 1'b0, 8'h22, 4'b0000, 4'b0100};
    tv[12] = '{4'b0001, 4'b0001, 32'h0000_0033, 1'b0, 1'b0, 8'h22, 4'b0000, 4'b0000};
    tv[13] = '{4'b0001, 4'b0001, 32'h0000_0033, 1'b0, 1'b1, 8'h33, 4'b0001, 4'b0001};
    tv[14] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0001};
    tv[15] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h33, 4'b0000, 4'b0001};
    tv[16] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0001};
    tv[17] = '{4'b1001, 4'b1000, 32'h4400_0055, 1'b0, 1'b0, 8'h33, 4'b0000, 4'b0000};
    tv[18] = '{4'b1001, 4'b1000, 32'h4400_0055, 1'b0, 1'b1, 8'h44, 4'b1000, 4'b1000};

    for (int i = 0; i < 19; i++) begin
      tick();
      vec_valid = tv[i].valid;
      vec_last  = tv[i].last;
      vec_data  = tv[i].data;
      vec_busy  = tv[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d_tx_start", i), 32'(tx_start), 32'(tv[i].e_start));
      check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tv[i].e_data));
      check($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tv[i].e_ready));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(tv[i].e_grant));
      check($sformatf("vec%0d_gap_timeout", i), 32'(gap_timeout), 32'd0);
    end
`endif

    // Switch to the models; hold reset long enough for the transmitter model to drain.
    tick();
    vec_valid = '0;
    vec_busy  = 1'b0;
    rst_n     = 1'b0;
    model_en  = 1'b1;
    repeat (25) tick();
    rst_n = 1'b1;

`ifdef UART_ARB_SRC_TAG_EN
    base  = log_d.size();
    rbase = rdy_cnt[3];
    add(3, 8'h7E, 1'b1);
    wait_done("tag", 200);
    check("tag_count", 32'(log_d.size() - base), 32'd2);
    check_log("tag_byte", base, 8'hA3, 4'b1000);
    check_log("tag_payload", base + 1, 8'h7E, 4'b1000);
    if (base + 1 < log_r.size()) begin
      check("tag_no_ready", 32'(log_r[base]), 32'd0);
      check("tag_payload_ready", 32'(log_r[base + 1]), 32'(4'b1000));
    end
    check("tag_ready_pulses", 32'(rdy_cnt[3] - rbase), 32'd1);
`else
    // Single packet from requester 2 at full frame length.
    base  = log_d.size();
    rbase = rdy_cnt[2];
    add(2, 8'h11, 1'b0);
    add(2, 8'h22, 1'b0);
    add(2, 8'h33, 1'b1);
    wait_done("single", 300);
    check("single_count", 32'(log_d.size() - base), 32'd3);
    check_log("single_b0", base, 8'h11, 4'b0100);
    check_log("single_b1", base + 1, 8'h22, 4'b0100);
    check_log("single_b2", base + 2, 8'h33, 4'b0100);
    check("single_ready_pulses", 32'(rdy_cnt[2] - rbase), 32'd3);
    check("single_grant_released", 32'(grant), 32'd0);
    // rr_ptr is now 3: with 0 and 3 requesting together, 3 goes first.
    base = log_d.size();
    add(0, 8'hE0, 1'b1);
    add(3, 8'hF0, 1'b1);
    wait_done("rr_after_single", 300);
    check_log("rr_first", base, 8'hF0, 4'b1000);
    check_log("rr_second", base + 1, 8'hE0, 4'b0001);

    // Contention: 0,1,3 with two-byte packets from rr_ptr=0; packets never interleave.
    do_reset();
    base = log_d.size();
    add(0, 8'hA0, 1'b0); add(0, 8'hA1, 1'b1);
    add(1, 8'hB0, 1'b0); add(1, 8'hB1, 1'b1);
    add(3, 8'hD0, 1'b0); add(3, 8'hD1, 1'b1);
    wait_done("contend", 800);
    check("contend_count", 32'(log_d.size() - base), 32'd6);
    check_log("contend0", base,     8'hA0, 4'b0001);
    check_log("contend1", base + 1, 8'hA1, 4'b0001);
    check_log("contend2", base + 2, 8'hB0, 4'b0010);
    check_log("contend3", base + 3, 8'hB1, 4'b0010);
    check_log("contend4", base + 4, 8'hD0, 4'b1000);
    check_log("contend5", base + 5, 8'hD1, 4'b1000);
    // rr_ptr wrapped to 0 after requester 3.
    base = log_d.size();
    add(1, 8'hC1, 1'b1);
    add(0, 8'hC0, 1'b1);
    wait_done("contend_wrap", 300);
    check_log("wrap_first", base, 8'hC0, 4'b0001);
    check_log("wrap_second", base + 1, 8'hC1, 4'b0010);

    // Busy pacing: transmitter held busy after the grant.
    hold_busy = 1'b1;
    base = log_d.size();
    add(1, 8'h5A, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = (grant != 4'b0000);
    end
    check("pace_grant", 32'(grant), 32'(4'b0010));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("pace_hold%0d", k), 32'(tx_start), 32'd0);
      tick();
    end
    hold_busy = 1'b0;
    rel_cyc   = cyc;
    wait_done("pace", 300);
    check("pace_count", 32'(log_d.size() - base), 32'd1);
    check_log("pace_byte", base, 8'h5A, 4'b0010);
    if (base < log_c.size()) check("pace_after_release", 32'(log_c[base] >= rel_cyc), 32'd1);

    // Gap timeout: requester 1 stalls after a non-last byte while 2 is pending.
    do_reset();
    base = log_d.size();
    g0   = gto_cnt;
    add(1, 8'h55, 1'b0);
    add(2, 8'h66, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      seen = (gto_cnt > g0);
    end
    check("gap_pulse_seen", 32'(seen), 32'd1);
    check_log("gap_first", base, 8'h55, 4'b0010);
    if (base < log_c.size()) check("gap_pulse_timing", 32'(gto_cyc - log_c[base]), 32'(FRAME + 2 + GAP));
    check("gap_grant_at_pulse", 32'(gto_grant), 32'd0);
    check("gap_next_grant", 32'(grant), 32'(4'b0100));
    wait_done("gap", 300);
    check_log("gap_second", base + 1, 8'h66, 4'b0100);
    check("gap_pulse_count", 32'(gto_cnt - g0), 32'd1);

    // Reset during WAIT_LO of byte 2 of 4; rr_ptr was 3 before the reset.
    do_reset();
    add(2, 8'h10, 1'b1);
    wait_done("pre_reset", 300);
    base = log_d.size();
    add(3, 8'h01, 1'b0); add(3, 8'h02, 1'b0); add(3, 8'h03, 1'b0); add(3, 8'h04, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      seen = (log_d.size() - base >= 2);
    end
    check("midrst_second_byte", 32'(seen), 32'd1);
    repeat (5) tick();
    rst_n  = 1'b0;
    len[3] = rd[3];
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    check("midrst_bytes_before", 32'(log_d.size() - base), 32'd2);
    tick();
    base2 = log_d.size();
    add(3, 8'h73, 1'b1);
    add(1, 8'h71, 1'b1);
    wait_done("post_reset", 300);
    check("post_reset_count", 32'(log_d.size() - base2), 32'd2);
    check_log("post_reset_first", base2, 8'h71, 4'b0010);
    check_log("post_reset_second", base2 + 1, 8'h73, 4'b1000);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
